// File: rtl/spi_master_cfg_if.sv
// Interface bundling the system-side handshake and the SPI pins of
// spi_master_cfg.
//   master modport : used by the SPI master core (drives dout/done/busy and
//                    the SPI pins sclk/cs/mosi; receives newd/din/miso).
//   slave modport  : used by the surrounding system and the SPI slave
//                    (drives newd/din/miso; observes everything else).
interface spi_master_cfg_if #(
  parameter int DATA_W = 12
);
  logic              newd;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              done;
  logic              busy;
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;

  modport master (
    input  newd, din, miso,
    output dout, done, busy, sclk, cs, mosi
  );

  modport slave (
    output newd, din, miso,
    input  dout, done, busy, sclk, cs, mosi
  );
endinterface

// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_master_cfg_if.master
//              newd/din   start request and transmit word (sampled in IDLE)
//              dout/done  received word and one-cycle completion pulse
//              busy       high from acceptance through the DONE cycle
//              sclk/cs/mosi/miso  SPI pins (cs active low)
// Sequence: IDLE -> SETUP (CLK_DIV) -> XFER (2*DATA_W half-periods of
// CLK_DIV) -> HOLD (CLK_DIV) -> DONE (1) -> IDLE. All outputs registered.
module spi_master_cfg #(
  parameter int DATA_W    = 12,
  parameter int CLK_DIV   = 4,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  spi_master_cfg_if.master   bus
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGES     = EDGE_W'(2 * DATA_W);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                sclk_q, sclk_d;
  logic                cs_q, cs_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                div_wrap;
  logic                fire;
  logic                sample_edge;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                 input logic b);
    return (LSB_FIRST != 0) ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    edge_cnt_d = edge_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    dout_d     = dout_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    fire       = 1'b0;
    div_wrap   = (div_q == DIV_LAST);
    // Even edge index = leading edge of an SCLK period.
    sample_edge = (CPHA == 0) ? ~edge_cnt_q[0] : edge_cnt_q[0];

    case (state_q)
      S_IDLE: begin
        if (bus.newd) begin
          state_d    = S_SETUP;
          div_d      = '0;
          edge_cnt_d = '0;
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          // CPHA=0 presents bit 0 now so it is stable before the first
          // leading (sampling) edge; the register then holds the rest.
          if (CPHA == 0) begin
            mosi_d = first_bit(bus.din);
            tx_d   = shift_out(bus.din);
          end else begin
            tx_d   = bus.din;
          end
        end
      end
      S_SETUP: begin
        if (div_wrap) begin
          div_d   = '0;
          state_d = S_XFER;
          fire    = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_XFER: begin
        // SCLK toggles at the start of each half-period; after the last
        // one it already rests at CPOL, so the final boundary only moves on.
        if (div_wrap) begin
          div_d = '0;
          if (edge_cnt_q == EDGES) state_d = S_HOLD;
          else                     fire    = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (div_wrap) begin
          div_d   = '0;
          state_d = S_DONE;
          cs_d    = 1'b1;
          done_d  = 1'b1;
          dout_d  = rx_q;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        mosi_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (fire) begin
      sclk_d     = ~sclk_q;
      edge_cnt_d = edge_cnt_q + 1'b1;
      if (sample_edge) begin
        rx_d = shift_in(rx_q, bus.miso);
      end else if (!((CPHA == 0) && (edge_cnt_q == LAST_EDGE))) begin
        mosi_d = first_bit(tx_q);
        tx_d   = shift_out(tx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      edge_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      dout_q     <= '0;
      sclk_q     <= (CPOL != 0);
      cs_q       <= 1'b1;
      mosi_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      edge_cnt_q <= edge_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      dout_q     <= dout_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      mosi_q     <= mosi_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.sclk = sclk_q;
  assign bus.cs   = cs_q;
  assign bus.mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: three configurations sharing clk/rst.
//   u0: defaults (12 bit, div 4, mode 0, LSB first), miso looped to mosi
//   u1: CPOL=1 CPHA=1 MSB first div 1, miso tied high
//   u2: 8 bit, div 2, mode 0, slave model answering 8'h3C
module tb_spi_master_cfg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [11:0] q0[$];
  logic [11:0] q1[$];
  logic [7:0]  q2[$];

  spi_master_cfg_if #(.DATA_W(12)) if0 ();
  spi_master_cfg_if #(.DATA_W(12)) if1 ();
  spi_master_cfg_if #(.DATA_W(8))  if2 ();

  spi_master_cfg #(.DATA_W(12), .CLK_DIV(4), .CPOL(0), .CPHA(0), .LSB_FIRST(1))
    u0 (.clk(clk), .rst(rst), .bus(if0));
  spi_master_cfg #(.DATA_W(12), .CLK_DIV(1), .CPOL(1), .CPHA(1), .LSB_FIRST(0))
    u1 (.clk(clk), .rst(rst), .bus(if1));
  spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .CPOL(0), .CPHA(0), .LSB_FIRST(1))
    u2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.miso = if0.mosi;
  assign if1.miso = 1'b1;

  // Mode-0 LSB-first slave: bit i stays on miso until the i-th rising edge.
  logic [7:0] resp = 8'h3C;
  logic [3:0] s_idx = '0;
  always @(posedge if2.sclk or posedge if2.cs)
    if (if2.cs) s_idx <= '0;
    else        s_idx <= s_idx + 4'd1;
  assign if2.miso = resp[s_idx[2:0]];

  // {busy, done, sclk, cs, mosi}
  function automatic logic [4:0] pins(input int sel);
    case (sel)
      0:       return {if0.busy, if0.done, if0.sclk, if0.cs, if0.mosi};
      1:       return {if1.busy, if1.done, if1.sclk, if1.cs, if1.mosi};
      default: return {if2.busy, if2.done, if2.sclk, if2.cs, if2.mosi};
    endcase
  endfunction

  task automatic drive(input int sel, input logic nd, input logic [11:0] d);
    case (sel)
      0:       begin if0.newd = nd; if0.din = d;      end
      1:       begin if1.newd = nd; if1.din = d;      end
      default: begin if2.newd = nd; if2.din = d[7:0]; end
    endcase
  endtask

  // Runs one transfer; lat is -1 if done never arrives within the budget.
  task automatic xfer(input int sel, input logic [11:0] d, input int poke_cyc,
                      output int lat, output int rises, output logic [11:0] seq,
                      output int cs_viol);
    logic [4:0] p;
    logic s_prev;
    lat = -1; rises = 0; seq = '0; cs_viol = 0;
    @(negedge clk); drive(sel, 1'b1, d);
    @(negedge clk); drive(sel, 1'b0, d);
    p = pins(sel); s_prev = p[2];
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == poke_cyc) drive(sel, 1'b1, 12'h111);
      else if (c == poke_cyc + 1) drive(sel, 1'b0, d);
      p = pins(sel);
      if (p[2] !== s_prev && p[1] !== 1'b0) cs_viol++;
      if (s_prev === 1'b0 && p[2] === 1'b1) begin
        if (rises < 12) seq[rises] = p[0];
        rises++;
      end
      s_prev = p[2];
      if (p[3] === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 1'b0, '0); drive(1, 1'b0, '0); drive(2, 1'b0, '0);
    repeat (2) @(negedge clk);
    checks++; if (if0.sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk0 got %b exp 0", if0.sclk); end
    checks++; if (if0.cs !== 1'b1) begin errors++; $display("FAIL rst_cs0 got %b exp 1", if0.cs); end
    checks++; if (if0.mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi0 got %b exp 0", if0.mosi); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL rst_done0 got %b exp 0", if0.done); end
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL rst_busy0 got %b exp 0", if0.busy); end
    checks++; if (if0.dout !== 12'h000) begin errors++; $display("FAIL rst_dout0 got %h exp 000", if0.dout); end
    checks++; if (if1.sclk !== 1'b1) begin errors++; $display("FAIL rst_sclk1 got %b exp 1", if1.sclk); end
    checks++; if (if2.cs !== 1'b1) begin errors++; $display("FAIL rst_cs2 got %b exp 1", if2.cs); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mode0_loopback;
    int lat, rises, viol;
    logic [11:0] seq, exp;
    q0.push_back(12'hA5C);
    xfer(0, 12'hA5C, -1, lat, rises, seq, viol);
    exp = (q0.size() > 0) ? q0[0] : 12'hXXX;
    if (q0.size() > 0) void'(q0.pop_front());
    checks++; if (lat !== 104) begin errors++; $display("FAIL t1_latency got %0d exp 104", lat); end
    checks++; if (rises !== 12) begin errors++; $display("FAIL t1_sclk_rises got %0d exp 12", rises); end
    checks++; if (seq !== 12'hA5C) begin errors++; $display("FAIL t1_mosi_order got %h exp a5c", seq); end
    checks++; if (if0.dout !== exp) begin errors++; $display("FAIL t1_dout got %h exp %h", if0.dout, exp); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL t1_sclk_while_cs_high got %0d exp 0", viol); end
  endtask

  task automatic test_mode3_msb;
    int lat, rises, viol;
    logic [11:0] seq, exp;
    checks++; if (if1.sclk !== 1'b1) begin errors++; $display("FAIL t2_idle_sclk got %b exp 1", if1.sclk); end
    q1.push_back(12'hFFF);
    xfer(1, 12'h000, -1, lat, rises, seq, viol);
    exp = (q1.size() > 0) ? q1[0] : 12'hXXX;
    if (q1.size() > 0) void'(q1.pop_front());
    checks++; if (lat !== 26) begin errors++; $display("FAIL t2_latency got %0d exp 26", lat); end
    checks++; if (rises !== 12) begin errors++; $display("FAIL t2_sclk_rises got %0d exp 12", rises); end
    checks++; if (seq !== 12'h000) begin errors++; $display("FAIL t2_mosi_bits got %h exp 000", seq); end
    checks++; if (if1.dout !== exp) begin errors++; $display("FAIL t2_dout got %h exp %h", if1.dout, exp); end
    checks++; if (if1.sclk !== 1'b1) begin errors++; $display("FAIL t2_sclk_after got %b exp 1", if1.sclk); end
  endtask

  task automatic test_w8_slave;
    int lat, rises, viol;
    logic [11:0] seq;
    logic [7:0] exp;
    q2.push_back(8'h3C);
    xfer(2, 12'h0C3, -1, lat, rises, seq, viol);
    exp = (q2.size() > 0) ? q2[0] : 8'hXX;
    if (q2.size() > 0) void'(q2.pop_front());
    checks++; if (lat !== 36) begin errors++; $display("FAIL t3_latency got %0d exp 36", lat); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL t3_sclk_rises got %0d exp 8", rises); end
    checks++; if (seq[7:0] !== 8'hC3) begin errors++; $display("FAIL t3_mosi_order got %h exp c3", seq[7:0]); end
    checks++; if (if2.dout !== exp) begin errors++; $display("FAIL t3_dout got %h exp %h", if2.dout, exp); end
    @(negedge clk);
    checks++; if (if2.busy !== 1'b0) begin errors++; $display("FAIL t3_busy_after got %b exp 0", if2.busy); end
    checks++; if (if2.done !== 1'b0) begin errors++; $display("FAIL t3_done_width got %b exp 0", if2.done); end
  endtask

  task automatic test_newd_busy;
    int lat, rises, viol, bcnt;
    logic [11:0] seq, exp;
    q0.push_back(12'h0F0);
    xfer(0, 12'h0F0, 20, lat, rises, seq, viol);
    exp = (q0.size() > 0) ? q0[0] : 12'hXXX;
    if (q0.size() > 0) void'(q0.pop_front());
    checks++; if (lat !== 104) begin errors++; $display("FAIL t4_latency got %0d exp 104", lat); end
    checks++; if (if0.dout !== exp) begin errors++; $display("FAIL t4_dout got %h exp %h", if0.dout, exp); end
    bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (if0.busy !== 1'b0 || if0.cs !== 1'b1) bcnt++;
    end
    checks++; if (bcnt !== 0) begin errors++; $display("FAIL t4_no_second_xfer got %0d busy cycles exp 0", bcnt); end
  endtask

  task automatic test_back_to_back;
    int acc, ndone, run, min_run, dbl;
    logic pb, pd;
    logic [11:0] exp;
    q0.push_back(12'h001); q0.push_back(12'h800); q0.push_back(12'hFFF);
    acc = 0; ndone = 0; run = 0; min_run = 999; dbl = 0;
    @(negedge clk);
    pb = if0.busy; pd = if0.done;
    if0.newd = 1'b1; if0.din = 12'h001;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (if0.busy === 1'b1 && pb === 1'b0) begin
        acc++;
        if (acc >= 2 && run < min_run) min_run = run;
        run = 0;
        if (acc == 1)      if0.din = 12'h800;
        else if (acc == 2) if0.din = 12'hFFF;
        else               if0.newd = 1'b0;
      end
      if (if0.cs === 1'b1) run++;
      if (if0.done === 1'b1) begin
        ndone++;
        exp = (q0.size() > 0) ? q0[0] : 12'hXXX;
        if (q0.size() > 0) void'(q0.pop_front());
        checks++; if (if0.dout !== exp) begin errors++; $display("FAIL t5_dout_%0d got %h exp %h", ndone, if0.dout, exp); end
        if (pd === 1'b1) dbl++;
      end
      pd = if0.done; pb = if0.busy;
      if (ndone == 3) break;
    end
    if0.newd = 1'b0;
    checks++; if (ndone !== 3) begin errors++; $display("FAIL t5_done_count got %0d exp 3", ndone); end
    checks++; if (acc !== 3) begin errors++; $display("FAIL t5_accept_count got %0d exp 3", acc); end
    checks++; if (min_run < 2) begin errors++; $display("FAIL t5_cs_gap got %0d exp >=2", min_run); end
    checks++; if (dbl !== 0) begin errors++; $display("FAIL t5_double_done got %0d exp 0", dbl); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int lat, rises, viol, bad;
    logic [11:0] seq, exp;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    checks++; if (if0.dout !== 12'h000) begin errors++; $display("FAIL t6_dout_pre got %h exp 000", if0.dout); end
    @(negedge clk); if0.newd = 1'b1; if0.din = 12'h3C3;
    @(negedge clk); if0.newd = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (if0.cs !== 1'b1) begin errors++; $display("FAIL t6_cs got %b exp 1", if0.cs); end
    checks++; if (if0.sclk !== 1'b0) begin errors++; $display("FAIL t6_sclk got %b exp 0", if0.sclk); end
    checks++; if (if0.busy !== 1'b0) begin errors++; $display("FAIL t6_busy got %b exp 0", if0.busy); end
    checks++; if (if0.done !== 1'b0) begin errors++; $display("FAIL t6_done got %b exp 0", if0.done); end
    checks++; if (if0.dout !== 12'h000) begin errors++; $display("FAIL t6_dout_kept got %h exp 000", if0.dout); end
    bad = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (if0.done !== 1'b0 || if0.busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL t6_no_resume got %0d cycles exp 0", bad); end
    q0.push_back(12'h5A5);
    xfer(0, 12'h5A5, -1, lat, rises, seq, viol);
    exp = (q0.size() > 0) ? q0[0] : 12'hXXX;
    if (q0.size() > 0) void'(q0.pop_front());
    checks++; if (lat !== 104) begin errors++; $display("FAIL t6_latency got %0d exp 104", lat); end
    checks++; if (if0.dout !== exp) begin errors++; $display("FAIL t6_dout got %h exp %h", if0.dout, exp); end
  endtask

  initial begin
    if0.newd = 1'b0; if0.din = '0;
    if1.newd = 1'b0; if1.din = '0;
    if2.newd = 1'b0; if2.din = '0;
    test_reset;
    test_mode0_loopback;
    test_mode3_msb;
    test_w8_slave;
    test_newd_busy;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
